cordic_iter: RTL and testbench



---
 rtl/cordic_pkg.sv | 49 ++++
 rtl/cordic_iter_if.sv | 30 +++
 rtl/cordic_atan_lut.sv | 25 ++
 rtl/cordic_iter.sv | 162 ++++++++++++++++
 tb/tb_cordic_iter.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
//==============================================================================
// Module : cordic_pkg
// Brief  : Shared constants and types for the iterative CORDIC engine.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package cordic_pkg;

  localparam logic signed [31:0] HALF_PI = 32'sh6487ED51;
  localparam logic signed [31:0] K_INV   = 32'sh26DD3B6A;
  localparam logic signed [31:0] ONE_Q230 = 32'sh40000000;

  // atan(2^-i) in Q2.30, rounded to nearest
  localparam logic signed [31:0] ATAN_TABLE [32] = '{
    32'sh3243F6A9, 32'sh1DAC6705, 32'sh0FADBAFD, 32'sh07F56EA7,
    32'sh03FEAB77, 32'sh01FFD55C, 32'sh00FFFAAB, 32'sh007FFF55,
    32'sh003FFFEB, 32'sh001FFFFD, 32'sh00100000, 32'sh00080000,
    32'sh00040000, 32'sh00020000, 32'sh00010000, 32'sh00008000,
    32'sh00004000, 32'sh00002000, 32'sh00001000, 32'sh00000800,
    32'sh00000400, 32'sh00000200, 32'sh00000100, 32'sh00000080,
    32'sh00000040, 32'sh00000020, 32'sh00000010, 32'sh00000008,
    32'sh00000004, 32'sh00000002, 32'sh00000001, 32'sh00000000
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic signed [63:0] q230_scale(input logic signed [31:0] v,
                                                     input int frac);
    logic signed [63:0] t;
    t = 64'(v);
    if (frac <= 30) return t >>> (30 - frac);
    return t <<< (frac - 30);
  endfunction

  function automatic logic signed [31:0] atan_q230(input int idx);
    logic [4:0] sel;
    if (idx < 0 || idx > 31) return 32'sd0;
    sel = idx[4:0];
    return ATAN_TABLE[sel];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_iter_if.sv
//==============================================================================
// Module : cordic_iter_if
// Brief  : Start/done handshake and result bus of the CORDIC engine.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface cordic_iter_if #(
  parameter int WIDTH = 18
);
  logic                    start;
  logic signed [WIDTH-1:0] in_angle;
  logic                    ready;
  logic                    done;
  logic signed [WIDTH-1:0] cos_out;
  logic signed [WIDTH-1:0] sin_out;
  logic                    range_err;

  modport master (
    output start, in_angle,
    input  ready, done, cos_out, sin_out, range_err
  );

  modport slave (
    input  start, in_angle,
    output ready, done, cos_out, sin_out, range_err
  );
endinterface

`default_nettype wire

// File: rtl/cordic_atan_lut.sv
//==============================================================================
// Module : cordic_atan_lut
// Brief  : Combinational atan(2^-i) lookup rescaled to WIDTH fractional bits.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int IDX_W = 5
) (
  input  wire logic [IDX_W-1:0]        i_idx,
  output logic signed [WIDTH+1:0]      o_atan
);

  // Output carries 2 integer bits and WIDTH fractional bits (incl. 2 guard bits)
  always_comb begin
    o_atan = (WIDTH+2)'(q230_scale(atan_q230(int'(i_idx)), WIDTH));
  end

endmodule

`default_nettype wire

// File: rtl/cordic_iter.sv
//==============================================================================
// Module : cordic_iter
// Brief  : Iterative CORDIC rotation, one micro-rotation per clock, cos/sin out.
//          Define CORDIC_GAIN_COMP_EN to pre-scale x by K_INV (unity gain).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module cordic_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int ITER  = 16
) (
  input wire logic     clock,
  input wire logic     init,
  cordic_iter_if.slave bus
);

  localparam int IW    = WIDTH + 2;
  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [CNT_W-1:0]   C_LAST        = CNT_W'(ITER - 1);
  localparam logic signed [IW-1:0] C_HALF_PI     = IW'(q230_scale(HALF_PI, WIDTH));
  localparam logic signed [IW-1:0] C_NEG_HALF_PI = -C_HALF_PI;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [IW-1:0] C_X0 = IW'(q230_scale(K_INV, WIDTH));
`else
  localparam logic signed [IW-1:0] C_X0 = IW'(q230_scale(ONE_Q230, WIDTH));
`endif

  state_e                  r_state;
  state_e                  w_next;
  logic                    w_accept;
  logic                    w_last;

  logic [CNT_W-1:0]        r_i;
  logic signed [IW-1:0]    r_x;
  logic signed [IW-1:0]    r_y;
  logic signed [IW-1:0]    r_z;
  logic signed [WIDTH-1:0] r_cos;
  logic signed [WIDTH-1:0] r_sin;
  logic                    r_err;
  logic                    r_err_ld;

  logic signed [IW-1:0]    w_atan;
  logic signed [IW-1:0]    w_ang;
  logic                    w_over;
  logic                    w_under;
  logic signed [IW-1:0]    w_zload;
  logic signed [IW-1:0]    w_xsh;
  logic signed [IW-1:0]    w_ysh;
  logic                    w_neg;
  logic signed [IW:0]      w_xn;
  logic signed [IW:0]      w_yn;
  logic signed [IW-1:0]    w_zn;
  logic signed [IW-1:0]    w_xsat;
  logic signed [IW-1:0]    w_ysat;

  function automatic logic signed [IW-1:0] sat(input logic signed [IW:0] v);
    if (v[IW] == v[IW-1]) return v[IW-1:0];
    return v[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
  endfunction

  cordic_atan_lut #(
    .WIDTH (WIDTH),
    .IDX_W (CNT_W)
  ) u_atan_lut (
    .i_idx  (r_i),
    .o_atan (w_atan)
  );

  always_ff @(posedge clock) begin
    if (init) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    bus.ready = (r_state != ST_RUN);
    bus.done  = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next   = ST_RUN;
          w_accept = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_i == C_LAST) begin
          w_next = ST_DONE;
          w_last = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          w_next   = ST_RUN;
          w_accept = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Angle compared at internal precision (input plus 2 guard bits)
  assign w_ang   = {bus.in_angle, 2'b00};
  assign w_over  = (w_ang > C_HALF_PI);
  assign w_under = (w_ang < C_NEG_HALF_PI);
  assign w_zload = w_over ? C_HALF_PI : (w_under ? C_NEG_HALF_PI : w_ang);

  assign w_neg  = r_z[IW-1];
  assign w_xsh  = r_x >>> r_i;
  assign w_ysh  = r_y >>> r_i;
  assign w_xn   = w_neg ? ({r_x[IW-1], r_x} + {w_ysh[IW-1], w_ysh})
                        : ({r_x[IW-1], r_x} - {w_ysh[IW-1], w_ysh});
  assign w_yn   = w_neg ? ({r_y[IW-1], r_y} - {w_xsh[IW-1], w_xsh})
                        : ({r_y[IW-1], r_y} + {w_xsh[IW-1], w_xsh});
  assign w_zn   = w_neg ? (r_z + w_atan) : (r_z - w_atan);
  assign w_xsat = sat(w_xn);
  assign w_ysat = sat(w_yn);

  // Last micro-rotation lands directly in the output registers
  always_ff @(posedge clock) begin
    if (init) begin
      r_i      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_cos    <= '0;
      r_sin    <= '0;
      r_err    <= 1'b0;
      r_err_ld <= 1'b0;
    end else if (w_accept) begin
      r_i      <= '0;
      r_x      <= C_X0;
      r_y      <= '0;
      r_z      <= w_zload;
      r_err_ld <= w_over | w_under;
    end else if (r_state == ST_RUN) begin
      r_x <= w_xsat;
      r_y <= w_ysat;
      r_z <= w_zn;
      r_i <= r_i + 1'b1;
      if (w_last) begin
        r_cos <= w_xsat[IW-1:2];
        r_sin <= w_ysat[IW-1:2];
        r_err <= r_err_ld;
      end
    end
  end

  assign bus.cos_out   = r_cos;
  assign bus.sin_out   = r_sin;
  assign bus.range_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cordic_iter.sv
//==============================================================================
// Module : tb_cordic_iter
// Brief  : Scoreboard bench for cordic_iter (WIDTH=18, ITER=16).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_cordic_iter;

  localparam int WIDTH = 18;
  localparam int ITER  = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int TOL   = 4;
  localparam int ONE   = 65536;
  localparam int COS30 = 56756;
  localparam int SIN30 = 32768;
  localparam int C45   = 46341;
`else
  localparam int TOL   = 8;
  localparam int ONE   = 107922;
  localparam int COS30 = 93463;
  localparam int SIN30 = 53961;
  localparam int C45   = 76312;
`endif

  logic clock = 1'b0;
  logic init;

  cordic_iter_if #(.WIDTH(WIDTH)) bus ();

  cordic_iter #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) dut (
    .clock (clock),
    .init  (init),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int   c;
    int   s;
    logic e;
    int   due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string name, int act, int req, int tol);
    total++;
    if (act > req + tol || act < req - tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d) at cycle %0d", name, act, req, tol, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clock) begin
    exp_t e;
    if (bus.done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
      end else begin
        e = q.pop_front();
        check("done_cycle", cyc, e.due, 0);
        check("cos_out", int'(bus.cos_out), e.c, TOL);
        check("sin_out", int'(bus.sin_out), e.s, TOL);
        check("range_err", int'(bus.range_err), int'(e.e), 0);
      end
    end
  end

  // Called at a negedge with the engine ready; returns one negedge later
  task automatic issue(int ang, int c, int s, logic er, bit expect_it);
    bus.start    = 1'b1;
    bus.in_angle = WIDTH'(ang);
    if (expect_it) q.push_back('{c: c, s: s, e: er, due: cyc + ITER + 1});
    @(negedge clock);
    bus.start    = 1'b0;
    bus.in_angle = WIDTH'($urandom);
  endtask

  task automatic wait_done(string name);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.done) return;
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got no done in 40 cycles want done", name);
  endtask

  task automatic run(string name, int ang, int c, int s, logic er);
    issue(ang, c, s, er, 1'b1);
    wait_done(name);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_angle = '0;
    init         = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_ready", int'(bus.ready), 1, 0);
    check("rst_done", int'(bus.done), 0, 0);
    check("rst_cos", int'(bus.cos_out), 0, 0);
    check("rst_sin", int'(bus.sin_out), 0, 0);
    check("rst_err", int'(bus.range_err), 0, 0);
    init = 1'b0;
    @(negedge clock);

    run("zero",   0,       ONE,   0,     1'b0);
    run("pi6",    34315,   COS30, SIN30, 1'b0);
    run("mpi4",   -51472,  C45,   -C45,  1'b0);
    run("clamp_p", 117965, 0,     ONE,   1'b1);
    run("clamp_n", -117965, 0,    -ONE,  1'b1);

    // Abort a run at iteration 8; no result may appear from it
    issue(34315, 0, 0, 1'b0, 1'b0);
    repeat (8) @(negedge clock);
    init = 1'b1;
    @(negedge clock);
    init = 1'b0;
    check("abort_ready", int'(bus.ready), 1, 0);
    check("abort_done", int'(bus.done), 0, 0);
    check("abort_cos", int'(bus.cos_out), 0, 0);
    check("abort_sin", int'(bus.sin_out), 0, 0);
    check("abort_err", int'(bus.range_err), 0, 0);
    @(negedge clock);
    run("after_abort", 0, ONE, 0, 1'b0);

    // Back-to-back start in the DONE cycle, plus starts during RUN to be ignored
    issue(34315, COS30, SIN30, 1'b0, 1'b1);
    wait_done("b2b_first");
    issue(-51472, C45, -C45, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
    bus.start    = 1'b1;
    bus.in_angle = '0;
    repeat (5) @(negedge clock);
    bus.start    = 1'b0;
    wait_done("b2b_second");
    repeat (25) @(negedge clock);
    check("queue_empty", q.size(), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time %0t want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
